// File: rtl/sprite_cmd_queue.sv
// Sprite command FIFO: replays HPS Avalon writes one word per clock onto the display command bus,
// holding buffer-swap words until vblank starts. Optional stats ports under CMD_QUEUE_STATS_EN.
module sprite_cmd_queue #(
  parameter int         DEPTH       = 16,
  parameter logic [9:0] VBLANK_LINE = 10'd480,
  parameter logic [3:0] SWAP_ACTION = 4'hF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    avs_chipselect,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic                    avs_waitrequest,
  input  logic [9:0]              hcount,
  input  logic [9:0]              vcount,
  output logic [31:0]             cmd_out,
  output logic                    front_buf,
  output logic                    swap_pending
`ifdef CMD_QUEUE_STATS_EN
  ,
  output logic [15:0]             frame_swaps,
  output logic [$clog2(DEPTH):0]  high_water
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    DRAIN    = 1'b0,
    WAIT_VBL = 1'b1
  } state_t;

  state_t          state, next_state;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [31:0]     head;
  logic            empty, push, pop, issue_swap, head_is_swap;
  logic            vbl_q, vbl_now, vbl_start;
  logic            unused_hcount;

  // vblank detection is level-edge on vcount only; hcount rate does not matter.
  assign unused_hcount = ^hcount;

  assign head            = mem[rd_ptr];
  assign empty           = (count == '0);
  assign head_is_swap    = (head[20:17] == SWAP_ACTION);
  assign avs_waitrequest = (count == FULL_CNT);
  assign push            = avs_chipselect & avs_write & ~avs_waitrequest;
  assign vbl_now         = (vcount == VBLANK_LINE);
  assign vbl_start       = vbl_now & ~vbl_q;
  assign swap_pending    = (state == WAIT_VBL);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    issue_swap = 1'b0;
    case (state)
      DRAIN: begin
        if (!empty) begin
          if (head_is_swap) next_state = WAIT_VBL;
          else              pop        = 1'b1;
        end
      end
      WAIT_VBL: begin
        // Everything behind the swap stays queued until this frame boundary.
        if (vbl_start) begin
          pop        = 1'b1;
          issue_swap = 1'b1;
          next_state = DRAIN;
        end
      end
      default: next_state = DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avs_writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DRAIN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_out   <= '0;
      front_buf <= 1'b0;
      vbl_q     <= 1'b0;
    end else begin
      state   <= next_state;
      vbl_q   <= vbl_now;
      cmd_out <= pop ? head : 32'h0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (issue_swap) front_buf <= head[13];
    end
  end

`ifdef CMD_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_swaps <= '0;
      high_water  <= '0;
    end else begin
      if (issue_swap)          frame_swaps <= frame_swaps + 16'd1;
      if (count > high_water)  high_water  <= count;
    end
  end
`endif

endmodule
